// File: rtl/dmem_mmio_responder.sv
// Data-memory responder: word RAM plus an MMIO page (cycle counter, compare timer, LED, switches).
// Read data is registered, 1 cycle after the address; there is no backpressure, so an access is accepted every cycle.
module dmem_mmio_responder #(
  parameter int unsigned DEPTH_LOG2 = 12,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_FF00
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address_dmem,
  input  logic [31:0] data,
  input  logic        wren,
  output logic [31:0] q_dmem,
  input  logic [15:0] switch_in,
  output logic [15:0] led_out,
  output logic        timer_irq,
  output logic        addr_err
);
  localparam logic [7:0] OFF_CYCLE  = 8'h00;
  localparam logic [7:0] OFF_LED    = 8'h01;
  localparam logic [7:0] OFF_SW     = 8'h02;
  localparam logic [7:0] OFF_TCMP   = 8'h03;
  localparam logic [7:0] OFF_STATUS = 8'h04;

  logic [31:0]           ram [2**DEPTH_LOG2];
  logic [31:0]           cycle_cnt;
  logic [31:0]           timer_cmp;
  logic [31:0]           mmio_rd;
  logic [15:0]           sw_sync1;
  logic [15:0]           sw_sync2;
  logic [7:0]            offset;
  logic [DEPTH_LOG2-1:0] ram_idx;
  logic                  is_mmio;
  logic                  is_ram;
  logic                  is_oor;
  logic                  timer_hit;
  logic                  wr_cycle;
  logic                  wr_led;
  logic                  wr_tcmp;
  logic                  wr_status;

  always_comb begin
    offset    = address_dmem[7:0];
    ram_idx   = address_dmem[DEPTH_LOG2-1:0];
    is_mmio   = (address_dmem[31:8] == MMIO_BASE[31:8]);
    is_ram    = !is_mmio && (address_dmem[31:DEPTH_LOG2] == '0);
    is_oor    = !is_mmio && !is_ram;
    timer_hit = (cycle_cnt == timer_cmp);
    wr_cycle  = is_mmio && wren && (offset == OFF_CYCLE);
    wr_led    = is_mmio && wren && (offset == OFF_LED);
    wr_tcmp   = is_mmio && wren && (offset == OFF_TCMP);
    wr_status = is_mmio && wren && (offset == OFF_STATUS);
  end

  // MMIO reads always see pre-edge register values.
  always_comb begin
    mmio_rd = '0;
    case (offset)
      OFF_CYCLE:  mmio_rd = cycle_cnt;
      OFF_LED:    mmio_rd = {16'b0, led_out};
      OFF_SW:     mmio_rd = {16'b0, sw_sync2};
      OFF_TCMP:   mmio_rd = timer_cmp;
      OFF_STATUS: mmio_rd = {30'b0, addr_err, timer_irq};
      default:    mmio_rd = '0;
    endcase
  end

  // RAM array has no reset so it can map onto block RAM; writes commit even during reset.
  always_ff @(posedge clock) begin
    if (wren && is_ram)
      ram[ram_idx] <= data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      q_dmem    <= '0;
      led_out   <= '0;
      cycle_cnt <= '0;
      timer_cmp <= '0;
      timer_irq <= 1'b0;
      addr_err  <= 1'b0;
      sw_sync1  <= '0;
      sw_sync2  <= '0;
    end else begin
      if (is_mmio)
        q_dmem <= mmio_rd;
      else if (is_ram)
        q_dmem <= wren ? data : ram[ram_idx];
      else
        q_dmem <= '0;

      cycle_cnt <= wr_cycle ? data : cycle_cnt + 32'd1;

      if (wr_led)
        led_out <= data[15:0];
      if (wr_tcmp)
        timer_cmp <= data;

      // Set beats write-1-clear when both land on the same edge.
      if (timer_hit)
        timer_irq <= 1'b1;
      else if (wr_status && data[0])
        timer_irq <= 1'b0;

      if (is_oor)
        addr_err <= 1'b1;
      else if (wr_status && data[1])
        addr_err <= 1'b0;

      sw_sync1 <= switch_in;
      sw_sync2 <= sw_sync1;
    end
  end
endmodule
